// File: rtl/mobo_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mobo_bus_arbiter
//   Shares the single motherboard memory port between two requesters:
//   port 0 (CPU read/write path) and port 1 (debug/DMA path).
//   Arbitration is round-robin with one transaction in flight. The block
//   sequences the mem_req/mem_ack handshake and returns read data, a
//   completion pulse and a timeout error flag per port.
//
// Parameters
//   WORD_WIDTH  width of address and data words
//   TIMEOUT     WAIT cycles allowed for mem_ack before aborting (1..2**TO_W-1)
//   TO_W        width of the timeout counter
//
// Ports
//   clk                 clock, all state changes on posedge
//   rst                 synchronous reset, active low
//   req0/req1           transaction request, held until done on that port
//   we0/we1             1 = write, 0 = read
//   addr0/addr1         request address
//   wdata0/wdata1       request write data
//   gnt0/gnt1           grant, from grant cycle through done cycle
//   done0/done1         one-cycle completion pulse
//   err0/err1           valid with done, 1 = timed out
//   rdata               read data, updated in done cycle, held until next done
//   mem_req             memory request, high until mem_ack sampled
//   mem_we              memory write strobe
//   mem_addr            memory address
//   mem_wdata           memory write data
//   mem_rdata           memory read data, valid with mem_ack
//   mem_ack             memory completion pulse
// ---------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module mobo_bus_arbiter #(
  parameter int WORD_WIDTH = `WORD_WIDTH,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [WORD_WIDTH-1:0] addr0,
  input  logic [WORD_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] wdata0,
  input  logic [WORD_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter value seen on the last allowed WAIT cycle: reaching it without
  // an ack means TIMEOUT WAIT cycles have elapsed.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t                state_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic                  last_port_r;   // port served most recently
  logic                  cur_port_r;    // port owning the current transaction

  logic                  pick_port_s;
  logic                  sel_we_s;
  logic [WORD_WIDTH-1:0] sel_addr_s;
  logic [WORD_WIDTH-1:0] sel_wdata_s;
  logic                  timeout_hit_s;

  // Round-robin winner: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    pick_port_s = 1'b0;
    if (req0 && req1) begin
      pick_port_s = ~last_port_r;
    end else if (req1) begin
      pick_port_s = 1'b1;
    end else begin
      pick_port_s = 1'b0;
    end
  end

  // Request fields of the winning port, latched into the mem_* registers at grant.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (pick_port_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Timeout detection on the current WAIT cycle.
  always_comb begin
    timeout_hit_s = 1'b0;
    if (to_cnt_r == TO_LAST) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      to_cnt_r    <= '0;
      last_port_r <= 1'b1;
      cur_port_r  <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      // done/err are single-cycle pulses; only the WAIT exit raises them.
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req0 || req1) begin
            cur_port_r  <= pick_port_s;
            last_port_r <= pick_port_s;
            gnt0        <= ~pick_port_s;
            gnt1        <= pick_port_s;
            mem_we      <= sel_we_s;
            mem_addr    <= sel_addr_s;
            mem_wdata   <= sel_wdata_s;
            state_r     <= ST_ISSUE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          mem_req  <= 1'b1;
          to_cnt_r <= '0;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          // An ack on the final allowed cycle still completes cleanly.
          if (mem_ack) begin
            if (!mem_we) begin
              rdata <= mem_rdata;
            end else begin
              rdata <= rdata;
            end
            mem_req <= 1'b0;
            done0   <= ~cur_port_r;
            done1   <= cur_port_r;
            state_r <= ST_DONE;
          end else if (timeout_hit_s) begin
            mem_req <= 1'b0;
            rdata   <= '0;
            done0   <= ~cur_port_r;
            done1   <= cur_port_r;
            err0    <= ~cur_port_r;
            err1    <= cur_port_r;
            state_r <= ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
            state_r  <= ST_WAIT;
          end
        end
        ST_DONE: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          mem_req <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mobo_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mobo_bus_arbiter
//   Directed, table-driven bench for mobo_bus_arbiter (TIMEOUT = 8).
//   Each table row gives the inputs applied before a clock edge and the
//   outputs expected just after it. A few hand sequences follow for the
//   write path and back-to-back grants.
// ---------------------------------------------------------------------------
module tb_mobo_bus_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, we0, we1;
  logic [W-1:0] addr0, addr1, wdata0, wdata1;
  logic         gnt0, gnt1, done0, done1, err0, err1;
  logic [W-1:0] rdata;
  logic         mem_req, mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack;

  int checks = 0;
  int errors = 0;

  logic         prev_mreq = 1'b0;
  logic         prev_we;
  logic [W-1:0] prev_addr, prev_wd;

  mobo_bus_arbiter #(.WORD_WIDTH(W), .TIMEOUT(8), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Outputs packed as {gnt0, gnt1, done0, done1, err0, err1, mem_req}
  typedef struct {
    logic         rst;
    logic         req0;
    logic         req1;
    logic         ack;
    logic [W-1:0] mrd;
    logic [6:0]   exp_o;
    logic [W-1:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic q0, input logic q1,
                              input logic a, input logic [W-1:0] d,
                              input logic [6:0] eo, input logic [W-1:0] erd);
    vec_t v;
    v.rst = r; v.req0 = q0; v.req1 = q1; v.ack = a; v.mrd = d;
    v.exp_o = eo; v.exp_rd = erd;
    return v;
  endfunction

  // Advance one edge, sample #1 later, and check grant exclusivity and
  // mem_* stability while mem_req stays high.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (gnt0 && gnt1) begin
      errors++;
      $display("FAIL gnt_onehot at %0t: gnt0=%b gnt1=%b, expected not both high", $time, gnt0, gnt1);
    end
    if (prev_mreq && mem_req) begin
      checks++;
      if (mem_addr != prev_addr || mem_wdata != prev_wd || mem_we != prev_we) begin
        errors++;
        $display("FAIL mem_stable at %0t: addr=%h wdata=%h we=%b, expected addr=%h wdata=%h we=%b",
                 $time, mem_addr, mem_wdata, mem_we, prev_addr, prev_wd, prev_we);
      end
    end
    prev_mreq = mem_req;
    prev_addr = mem_addr;
    prev_wd   = mem_wdata;
    prev_we   = mem_we;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic [6:0] act_o;
    bit         found;

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    we0 = 1'b0; we1 = 1'b1;
    addr0 = 16'h0010; addr1 = 16'h0020;
    wdata0 = 16'h0000; wdata1 = 16'h0055;
    mem_rdata = 16'h0000; mem_ack = 1'b0;

    // Reset
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'h0000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'h0000));
    // Port 0 read, ack after 3 WAIT cycles
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000000, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h0000));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 16'hCAFE, 7'b1010000, 16'hCAFE));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'hCAFE));
    // Stray ack in IDLE is ignored
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 16'hDEAD, 7'b0000000, 16'hCAFE));
    // Port 1 write: rdata keeps its old value
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 7'b0100000, 16'hCAFE));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 7'b0100001, 16'hCAFE));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 7'b0101000, 16'hCAFE));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'hCAFE));
    // Both requesting: grants alternate 0,1,0,1
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b1000000, 16'hCAFE));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b1000001, 16'hCAFE));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 7'b1010000, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b0000000, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b0100000, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b0100001, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h7777, 7'b0101000, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b0000000, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b1000000, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b1000001, 16'h0001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 7'b1010000, 16'h0002));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b0000000, 16'h0002));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b0100000, 16'h0002));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 7'b0100001, 16'h0002));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 16'h8888, 7'b0101000, 16'h0002));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'h0002));
    // Timeout: 8 WAIT cycles, then done0+err0, rdata cleared
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000000, 16'h0002));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h0002));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h0002));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1010100, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'h0000));
    // Ack on the last allowed WAIT cycle wins over timeout
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000000, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h0000));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 7'b1010000, 16'h1234));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'h1234));
    // Reset during WAIT aborts without done; a later req0 completes
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000000, 16'h1234));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h1234));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h1234));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000000, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 7'b1000001, 16'h0000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 16'h0BAD, 7'b1010000, 16'h0BAD));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'b0000000, 16'h0BAD));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req0 = vecs[i].req0; req1 = vecs[i].req1;
      mem_ack = vecs[i].ack; mem_rdata = vecs[i].mrd;
      tick();
      act_o = {gnt0, gnt1, done0, done1, err0, err1, mem_req};
      checks++;
      if (act_o !== vecs[i].exp_o || rdata !== vecs[i].exp_rd) begin
        errors++;
        $display("FAIL vec%0d: outs(g0 g1 d0 d1 e0 e1 mreq) got %b expected %b, rdata got %h expected %h",
                 i, act_o, vecs[i].exp_o, rdata, vecs[i].exp_rd);
      end
    end
    mem_ack = 1'b0;

    // Write path: mem_* carries port 1 request while mem_req is high
    req1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (mem_req) found = 1'b1;
    end
    check("wr_mem_req_seen", {31'd0, found}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("wr_mem_we", {31'd0, mem_we}, 32'd1);
      check("wr_mem_addr", {16'd0, mem_addr}, 32'h0000_0020);
      check("wr_mem_wdata", {16'd0, mem_wdata}, 32'h0000_0055);
      check("wr_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
      if (i < 2) tick();
    end
    mem_ack = 1'b1; mem_rdata = 16'hF00D;
    tick();
    mem_ack = 1'b0; req1 = 1'b0;
    check("wr_done1_err1", {30'd0, done1, err1}, 32'd2);
    check("wr_rdata_kept", {16'd0, rdata}, 32'h0000_0BAD);
    tick();
    check("wr_release", {29'd0, gnt1, done1, mem_req}, 32'd0);

    // Back-to-back: req0 held, re-granted the cycle after DONE
    req0 = 1'b1;
    tick();                                  // grant
    check("b2b_gnt0_first", {31'd0, gnt0}, 32'd1);
    tick();                                  // mem_req up
    mem_ack = 1'b1; mem_rdata = 16'h00A5;
    tick();                                  // DONE
    mem_ack = 1'b0;
    check("b2b_done0", {31'd0, done0}, 32'd1);
    check("b2b_rdata", {16'd0, rdata}, 32'h0000_00A5);
    tick();                                  // back to IDLE
    check("b2b_gnt0_gap", {31'd0, gnt0}, 32'd0);
    tick();                                  // re-grant
    check("b2b_gnt0_again", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;                             // drop mid-transaction: still completes
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h005A;
    tick();
    mem_ack = 1'b0;
    check("b2b_done0_after_drop", {30'd0, done0, err0}, 32'd2);
    check("b2b_rdata2", {16'd0, rdata}, 32'h0000_005A);
    tick();
    check("b2b_idle", {28'd0, gnt0, gnt1, done0, mem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
